// File: rtl/secp256k1_resp_router_pkg.sv
// Default geometry for the secp256k1 result return path. The entry layout is
// parameter-dependent, so it lives in the modules rather than here.
package secp256k1_resp_router_pkg;

    localparam int RR_NUM_OUT    = 2;
    localparam int RR_DAT_BITS   = 256;
    localparam int RR_CTL_BITS   = 8;
    localparam int RR_FIFO_DEPTH = 4;

endpackage

// File: rtl/secp256k1_resp_fifo.sv
// Sync FIFO with the head entry on o_dat (zero when empty). Write to read takes 1 cycle.
// A push while full and a pop while empty are both ignored. The caller gates them.
module secp256k1_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_dat   = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/secp256k1_resp_router.sv
// Steers tagged results from the shared secp256k1 unit to per-requester FIFOs. Latency is 1 cycle into an empty FIFO.
// o_rdy drops only when the FIFO addressed by the current tag is full. Bad tags are always consumed.
module secp256k1_resp_router
    import secp256k1_resp_router_pkg::*;
#(
    parameter int NUM_OUT    = RR_NUM_OUT,
    parameter int DAT_BITS   = RR_DAT_BITS,
    parameter int CTL_BITS   = RR_CTL_BITS,
    parameter int FIFO_DEPTH = RR_FIFO_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [DAT_BITS-1:0]          i_dat,
    input  logic [CTL_BITS-1:0]          i_ctl,
    input  logic                         i_err,
    input  logic                         i_val,
    output logic                         o_rdy,
    output logic [NUM_OUT*DAT_BITS-1:0]  o_dat,
    output logic [NUM_OUT*CTL_BITS-1:0]  o_ctl,
    output logic [NUM_OUT-1:0]           o_err,
    output logic [NUM_OUT-1:0]           o_val,
    input  logic [NUM_OUT-1:0]           i_rdy,
    output logic                         o_bad_tag
);

    localparam int SEL_BITS = $clog2(NUM_OUT);
    localparam int ENT_BITS = DAT_BITS + CTL_BITS + 1;

    logic [SEL_BITS-1:0] tag;
    logic [CTL_BITS-1:0] ctl_clr;
    logic [NUM_OUT-1:0]  hit;
    logic [NUM_OUT-1:0]  full;
    logic [NUM_OUT-1:0]  empty;
    logic [NUM_OUT-1:0]  push;
    logic [NUM_OUT-1:0]  pop;
    logic [ENT_BITS-1:0] head [NUM_OUT];
    logic                tag_full;
    logic                tag_bad;
    logic                accept;

    assign tag = i_ctl[CTL_BITS-1 -: SEL_BITS];

    always_comb begin
        ctl_clr = i_ctl;
        ctl_clr[CTL_BITS-1 -: SEL_BITS] = '0;
    end

    always_comb begin
        hit      = '0;
        tag_full = 1'b0;
        for (int n = 0; n < NUM_OUT; n++) begin
            hit[n]   = (tag == SEL_BITS'(n));
            tag_full = tag_full | (hit[n] & full[n]);
        end
        tag_bad = ~|hit;
    end

    // No write-through when full: a same-cycle pop still leaves o_rdy low.
    assign o_rdy  = i_rst_n & (tag_bad | ~tag_full);
    assign accept = i_val & o_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bad_tag <= 1'b0;
        end else if (accept && tag_bad) begin
            o_bad_tag <= 1'b1;
        end
    end

    for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
        assign push[n] = accept & hit[n];
        assign pop[n]  = ~empty[n] & i_rdy[n];

        secp256k1_resp_fifo #(
            .WIDTH (ENT_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (push[n]),
            .i_dat   ({i_dat, ctl_clr, i_err}),
            .i_pop   (pop[n]),
            .o_dat   (head[n]),
            .o_full  (full[n]),
            .o_empty (empty[n])
        );

        assign o_val[n]                        = ~empty[n];
        assign o_dat[n*DAT_BITS +: DAT_BITS]   = head[n][ENT_BITS-1 -: DAT_BITS];
        assign o_ctl[n*CTL_BITS +: CTL_BITS]   = head[n][CTL_BITS:1];
        assign o_err[n]                        = head[n][0];
    end

endmodule

// File: tb/tb_secp256k1_resp_router.sv
// Bench for secp256k1_resp_router: a per-requester queue model checked every negedge, plus directed literal checks.
module tb_secp256k1_resp_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [255:0] i_dat;
    logic [7:0]   i_ctl;
    logic         i_err, i_val, o_rdy, o_bad_tag;
    logic [511:0] o_dat;
    logic [15:0]  o_ctl;
    logic [1:0]   o_err, o_val, i_rdy;

    logic [255:0] b_dat;
    logic [7:0]   b_ctl;
    logic         b_err, b_val, b_o_rdy, b_bad;
    logic [767:0] b_o_dat;
    logic [23:0]  b_o_ctl;
    logic [2:0]   b_o_err, b_o_val, b_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    secp256k1_resp_router dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_ctl(i_ctl), .i_err(i_err),
        .i_val(i_val), .o_rdy(o_rdy), .o_dat(o_dat), .o_ctl(o_ctl), .o_err(o_err),
        .o_val(o_val), .i_rdy(i_rdy), .o_bad_tag(o_bad_tag)
    );

    secp256k1_resp_router #(.NUM_OUT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(b_dat), .i_ctl(b_ctl), .i_err(b_err),
        .i_val(b_val), .o_rdy(b_o_rdy), .o_dat(b_o_dat), .o_ctl(b_o_ctl), .o_err(b_o_err),
        .o_val(b_o_val), .i_rdy(b_rdy), .o_bad_tag(b_bad)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Model: one queue per requester holding what that requester has yet to receive.
    typedef struct {
        logic [255:0] d;
        logic [7:0]   c;
        logic         e;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];

    always @(negedge clk) begin : model
        ent_t ent;
        logic exp_rdy;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            chk("m_rst_val", o_val, 0);
            chk("m_rst_rdy", o_rdy, 0);
            chk("m_rst_dat", o_dat, 0);
        end else begin
            exp_rdy = i_ctl[7] ? (q1.size() < 4) : (q0.size() < 4);
            chk("m_val", o_val, {q1.size() != 0, q0.size() != 0});
            chk("m_rdy", o_rdy, exp_rdy);
            chk("m_bad", o_bad_tag, 0);
            if (q0.size() != 0) begin
                chk("m_dat0", o_dat[255:0], q0[0].d);
                chk("m_ctl0", o_ctl[7:0], q0[0].c);
                chk("m_err0", o_err[0], q0[0].e);
                if (i_rdy[0]) void'(q0.pop_front());
            end
            if (q1.size() != 0) begin
                chk("m_dat1", o_dat[511:256], q1[0].d);
                chk("m_ctl1", o_ctl[15:8], q1[0].c);
                chk("m_err1", o_err[1], q1[0].e);
                if (i_rdy[1]) void'(q1.pop_front());
            end
            if (i_val && exp_rdy) begin
                ent.d = i_dat;
                ent.c = {1'b0, i_ctl[6:0]};
                ent.e = i_err;
                if (i_ctl[7]) q1.push_back(ent);
                else          q0.push_back(ent);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        i_val = 0; i_ctl = 0; i_dat = 0; i_err = 0; i_rdy = 2'b11;
        b_val = 0; b_ctl = 0; b_dat = 0; b_err = 0; b_rdy = 3'b111;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_val", o_val, 0);
        chk("reset_rdy", o_rdy, 0);
        chk("reset_bad", o_bad_tag, 0);
        chk("reset_dat", o_dat, 0);
        chk("reset_ctl", o_ctl, 0);
        chk("reset_err", o_err, 0);
        chk("reset_val3", b_o_val, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("rdy_after_reset", o_rdy, 1);
        tick();

        // Basic routing
        i_val = 1; i_ctl = 8'h85; i_dat = 256'h1234; tick();
        chk("route1_val", o_val, 2'b10);
        chk("route1_ctl", o_ctl[15:8], 8'h05);
        chk("route1_dat", o_dat[511:256], 256'h1234);
        i_ctl = 8'h03; i_dat = 256'h55; tick();
        chk("route0_val", o_val, 2'b01);
        chk("route0_ctl", o_ctl[7:0], 8'h03);
        chk("route0_dat", o_dat[255:0], 256'h55);
        i_val = 0; tick();
        chk("idle_val", o_val, 0);

        // Back-pressure isolation
        i_rdy = 2'b10;
        for (int k = 0; k < 4; k++) begin
            i_val = 1; i_ctl = 8'(k); i_dat = 256'h100 + 256'(k); tick();
        end
        i_ctl = 8'h04; i_dat = 256'h104;
        #1 chk("bp_rdy_low", o_rdy, 0);
        chk("bp_full_val", o_val[0], 1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            i_ctl = 8'h80 + 8'(k); i_dat = 256'h200 + 256'(k);
            #1 chk("bp_tag1_rdy", o_rdy, 1);
            tick();
            chk("bp_tag1_val", o_val[1], 1);
            chk("bp_tag1_order", o_dat[511:256], 256'h200 + 256'(k));
        end
        i_val = 0; tick();

        // Full FIFO with a same-cycle pop
        i_val = 1; i_ctl = 8'h04; i_dat = 256'h104; i_rdy = 2'b11;
        #1 chk("fp_rdy_full", o_rdy, 0);
        for (int k = 0; k < 5; k++) begin
            chk("fp_val", o_val[0], 1);
            chk("fp_order", o_dat[255:0], 256'h100 + 256'(k));
            tick();
            if (k == 0) chk("fp_rdy_next", o_rdy, 1);
            if (k == 1) i_val = 0;
        end
        chk("fp_drained", o_val[0], 0);

        // Error propagation
        i_val = 1; i_ctl = 8'h80; i_dat = 256'h7; i_err = 1; tick();
        chk("err_set", o_err, 2'b10);
        i_ctl = 8'h81; i_dat = 256'h8; i_err = 0; tick();
        chk("err_next_clr", o_err[1], 0);
        chk("err_next_val", o_val[1], 1);
        i_val = 0; tick();

        // Bad tag on the three-requester instance
        b_val = 1; b_ctl = 8'hC1; b_dat = 256'h9;
        #1 chk("bt_rdy", b_o_rdy, 1);
        chk("bt_pre", b_bad, 0);
        tick();
        chk("bt_flag", b_bad, 1);
        chk("bt_noval", b_o_val, 0);
        b_ctl = 8'h8A; b_dat = 256'hA; tick();
        b_val = 0;
        chk("bt_route2_val", b_o_val, 3'b100);
        chk("bt_route2_ctl", b_o_ctl[23:16], 8'h0A);
        chk("bt_route2_dat", b_o_dat[767:512], 256'hA);
        tick(); tick();
        chk("bt_sticky", b_bad, 1);
        chk("bt_idle", b_o_val, 0);

        // Reset mid-stream
        i_rdy = 2'b00; i_val = 1;
        for (int k = 0; k < 3; k++) begin
            i_ctl = (k == 2) ? 8'h80 : 8'h00; i_dat = 256'h300 + 256'(k); tick();
        end
        i_val = 0;
        chk("rs_buffered", o_val, 2'b11);
        rst_n = 1'b0;
        #1 chk("rs_val", o_val, 0);
        chk("rs_rdy", o_rdy, 0);
        chk("rs_dat", o_dat, 0);
        chk("rs_bad3", b_bad, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("rs_rdy_after", o_rdy, 1);
        chk("rs_empty", o_val, 0);
        i_rdy = 2'b11;
        tick();
        chk("rs_no_replay", o_val, 0);
        i_val = 1; i_ctl = 8'h01; i_dat = 256'h400; tick();
        i_val = 0;
        chk("post_val", o_val, 2'b01);
        chk("post_dat", o_dat[255:0], 256'h400);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
